// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT stage datapath.
// Holds the stage FSM encoding and the butterfly stride helper.
package ntt_pkg;

  localparam int Q        = 257;
  localparam int LOGQ_DEF = 9;
  localparam int LOGN_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    PLUS,
    MINUS,
    DONE
  } state_e;

  // Distance between the two operands of a butterfly in stage s.
  function automatic int unsigned pair_stride(input int unsigned s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/ntt_stage_seq_if.sv
// Coefficient RAM, twiddle ROM and PE bus of the NTT stage sequencer.
// master: the sequencer; slave: memories and butterfly PE.
interface ntt_stage_seq_if
  import ntt_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF,
  parameter int LOGN = LOGN_DEF
);
  logic [LOGN-1:0] coef_raddr_a;
  logic [LOGN-1:0] coef_raddr_b;
  logic [LOGQ-1:0] coef_rdata_a;
  logic [LOGQ-1:0] coef_rdata_b;
  logic [LOGN-2:0] tw_raddr;
  logic [LOGQ-1:0] tw_rdata;
  logic [LOGQ-1:0] pe_a;
  logic [LOGQ-1:0] pe_b;
  logic [LOGQ-1:0] pe_c;
  logic            pe_sub;
  logic [LOGQ-1:0] pe_s;
  logic            coef_we;
  logic [LOGN-1:0] coef_waddr;
  logic [LOGQ-1:0] coef_wdata;

  modport master (
    output coef_raddr_a, coef_raddr_b, tw_raddr,
    output pe_a, pe_b, pe_c, pe_sub,
    output coef_we, coef_waddr, coef_wdata,
    input  coef_rdata_a, coef_rdata_b, tw_rdata, pe_s
  );

  modport slave (
    input  coef_raddr_a, coef_raddr_b, tw_raddr,
    input  pe_a, pe_b, pe_c, pe_sub,
    input  coef_we, coef_waddr, coef_wdata,
    output coef_rdata_a, coef_rdata_b, tw_rdata, pe_s
  );
endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator for one radix-2 Cooley-Tukey stage.
// Maps butterfly index k and stage s to operand and twiddle addresses.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOGN = LOGN_DEF,
  parameter int SW   = $clog2(LOGN) + 1
) (
  input  logic [LOGN-2:0] k,
  input  logic [SW-1:0]   s,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-2:0] tw_idx
);

  logic [LOGN-1:0] kx;
  logic [LOGN-1:0] half;
  logic [LOGN-1:0] j;

  always_comb begin
    kx     = {1'b0, k};
    half   = '0;
    j      = '0;
    addr_a = '0;
    addr_b = '0;
    tw_idx = '0;
    if (int'(s) < LOGN) begin
      half   = LOGN'(pair_stride(32'(s)));
      j      = kx & (half - LOGN'(1));
      addr_a = (((kx >> s) << s) << 1) | j;
      addr_b = addr_a | half;
      tw_idx = (LOGN-1)'(j << (LOGN - 1 - int'(s)));
    end
  end

endmodule

// File: rtl/ntt_stage_seq.sv
// Sequencer for one in-place radix-2 NTT stage feeding ntt_pe.
// Each butterfly: READ, LOAD, PLUS (a+bc), MINUS (a-bc).
module ntt_stage_seq
  import ntt_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF,
  parameter int LOGN = LOGN_DEF,
  parameter int SW   = $clog2(LOGN) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] stage,
  output logic          busy,
  output logic          done,
  ntt_stage_seq_if.master bus
);

  localparam logic [LOGN-2:0] K_LAST = '1;

  state_e          state_q, state_d;
  logic [LOGN-2:0] k_q, k_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [LOGN-1:0] ra_q, ra_d;
  logic [LOGN-1:0] rb_q, rb_d;
  logic [LOGN-2:0] tw_q, tw_d;
  logic [LOGQ-1:0] pa_q, pa_d;
  logic [LOGQ-1:0] pb_q, pb_d;
  logic [LOGQ-1:0] pc_q, pc_d;
  logic            sub_q, sub_d;

  logic [LOGN-1:0] gen_a;
  logic [LOGN-1:0] gen_b;
  logic [LOGN-2:0] gen_tw;

  // Addresses are generated for the next butterfly so they are
  // already registered when READ begins.
  ntt_addr_gen #(
    .LOGN (LOGN),
    .SW   (SW)
  ) u_addr_gen (
    .k      (k_d),
    .s      (stage_d),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          stage_d = stage;
          k_d     = '0;
          state_d = (int'(stage) >= LOGN) ? DONE : READ;
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        pa_d    = bus.coef_rdata_a;
        pb_d    = bus.coef_rdata_b;
        pc_d    = bus.tw_rdata;
        state_d = PLUS;
      end
      PLUS: state_d = MINUS;
      MINUS: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + (LOGN-1)'(1);
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sub_d = (state_d == MINUS);
    ra_d  = (state_d == READ) ? gen_a  : ra_q;
    rb_d  = (state_d == READ) ? gen_b  : rb_q;
    tw_d  = (state_d == READ) ? gen_tw : tw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      tw_q    <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      pc_q    <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      tw_q    <= tw_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pc_q    <= pc_d;
      sub_q   <= sub_d;
    end
  end

  assign busy = (state_q == READ) || (state_q == LOAD) ||
                (state_q == PLUS) || (state_q == MINUS);
  assign done = (state_q == DONE);

  assign bus.coef_raddr_a = ra_q;
  assign bus.coef_raddr_b = rb_q;
  assign bus.tw_raddr     = tw_q;
  assign bus.pe_a         = pa_q;
  assign bus.pe_b         = pb_q;
  assign bus.pe_c         = pc_q;
  assign bus.pe_sub       = sub_q;
  assign bus.coef_we      = (state_q == PLUS) || (state_q == MINUS);
  assign bus.coef_waddr   = (state_q == PLUS)  ? ra_q :
                            (state_q == MINUS) ? rb_q : '0;
  assign bus.coef_wdata   = bus.pe_s;

endmodule

// File: tb/tb_ntt_stage_seq.sv
// Bench for ntt_stage_seq: behavioural RAM/ROM/PE, NTT stage model,
// write scoreboard checked by an independent monitor.
module tb_ntt_stage_seq;
  import ntt_pkg::*;

  localparam int LOGQ = 9;
  localparam int LOGN = 3;
  localparam int SW   = 3;
  localparam int NPTS = 8;
  localparam int NTW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] stage = '0;
  logic          busy;
  logic          done;

  ntt_stage_seq_if #(.LOGQ(LOGQ), .LOGN(LOGN)) bus ();

  ntt_stage_seq #(.LOGQ(LOGQ), .LOGN(LOGN), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stage (stage),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [LOGQ-1:0] ram [NPTS];
  logic [LOGQ-1:0] rom [NTW];
  logic [LOGQ-1:0] img [NPTS];
  logic            ld = 1'b0;

  always @(posedge clk) begin
    bus.coef_rdata_a <= ram[bus.coef_raddr_a];
    bus.coef_rdata_b <= ram[bus.coef_raddr_b];
    bus.tw_rdata     <= rom[bus.tw_raddr];
    if (ld) begin
      for (int i = 0; i < NPTS; i++) ram[i] <= img[i];
    end else if (bus.coef_we) begin
      ram[bus.coef_waddr] <= bus.coef_wdata;
    end
  end

  function automatic logic [LOGQ-1:0] pe_f(input logic [LOGQ-1:0] a,
      input logic [LOGQ-1:0] b, input logic [LOGQ-1:0] c, input logic sub);
    int t;
    int r;
    t = (int'(b) * int'(c)) % Q;
    r = sub ? (int'(a) + Q - t) % Q : (int'(a) + t) % Q;
    return LOGQ'(r);
  endfunction

  assign bus.pe_s = pe_f(bus.pe_a, bus.pe_b, bus.pe_c, bus.pe_sub);

  typedef struct {
    int addr;
    int data;
    bit sub;
  } wr_t;

  wr_t exp_q[$];
  int  tw_seen[$];
  int  ref_m [NPTS];
  int  vectors = 0;
  int  miscompares = 0;

  int s0_req [NPTS] = '{3, 256, 7, 256, 11, 256, 15, 256};
  int s1_req [NPTS] = '{0, 0, 0, 0, 2, 6, 0, 253};

  function automatic void check(input string name, input int act,
                                input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.coef_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", int'(bus.coef_waddr), e.addr);
        check("wdata", int'(bus.coef_wdata), e.data);
        check("pe_sub", int'(bus.pe_sub), int'(e.sub));
      end
      if (!bus.pe_sub) tw_seen.push_back(int'(bus.tw_raddr));
    end
  end

  // Plain NTT stage: groups of 2*half, twiddle w^(j*NPTS/(2*half)).
  task automatic model_stage(input int s, input int nbf);
    int  half, step, cnt, a, b, w, x, y, t;
    wr_t e;
    if (s >= LOGN) return;
    half = 1 << s;
    step = NPTS / (2 * half);
    cnt  = 0;
    for (int base = 0; base < NPTS; base += 2 * half) begin
      for (int j = 0; j < half; j++) begin
        if (cnt < nbf) begin
          a = base + j;
          b = a + half;
          w = int'(rom[j * step]);
          x = ref_m[a];
          y = ref_m[b];
          t = (w * y) % Q;
          ref_m[a] = (x + t) % Q;
          ref_m[b] = (x + Q - t) % Q;
          e.addr = a; e.data = ref_m[a]; e.sub = 1'b0;
          exp_q.push_back(e);
          e.addr = b; e.data = ref_m[b]; e.sub = 1'b1;
          exp_q.push_back(e);
        end
        cnt++;
      end
    end
  endtask

  task automatic commit_img();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    for (int i = 0; i < NPTS; i++) ref_m[i] = int'(img[i]);
  endtask

  task automatic check_ram();
    for (int i = 0; i < NPTS; i++) check("ram", int'(ram[i]), ref_m[i]);
  endtask

  task automatic run_stage(input int s, input int exp_cyc);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    @(negedge clk);
    stage = SW'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (done) begin
        seen = 1'b1;
        cyc  = i;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", int'(seen), 1);
    if (seen) check("done_cycle", cyc, exp_cyc);
    @(negedge clk);
    check("done_width", int'(done), 0);
    check("writes_left", exp_q.size(), 0);
    check_ram();
  endtask

  initial begin
    int d1, d2, nd, s;
    for (int i = 0; i < NTW; i++) rom[i] = '0;
    for (int i = 0; i < NPTS; i++) img[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(bus.coef_we), 0);
    check("rst_pe_a", int'(bus.pe_a), 0);
    check("rst_pe_sub", int'(bus.pe_sub), 0);
    check("rst_raddr_a", int'(bus.coef_raddr_a), 0);
    check("rst_raddr_b", int'(bus.coef_raddr_b), 0);
    check("rst_tw", int'(bus.tw_raddr), 0);
    rst_n = 1'b1;

    for (int i = 0; i < NPTS; i++) img[i] = LOGQ'(i + 1);
    for (int i = 0; i < NTW; i++) rom[i] = LOGQ'(1);
    commit_img();
    model_stage(0, NPTS / 2);
    run_stage(0, 1 + 2 * NPTS);
    for (int i = 0; i < NPTS; i++) check("s0_const", int'(ram[i]), s0_req[i]);

    for (int i = 0; i < NPTS; i++) img[i] = LOGQ'(i + 1);
    for (int i = 0; i < NTW; i++) rom[i] = LOGQ'(i + 1);
    commit_img();
    model_stage(2, NPTS / 2);
    run_stage(2, 1 + 2 * NPTS);

    for (int i = 0; i < NPTS; i++) img[i] = (i < 4) ? '0 : LOGQ'(1);
    rom[0] = LOGQ'(1); rom[1] = '0; rom[2] = LOGQ'(5); rom[3] = '0;
    commit_img();
    tw_seen.delete();
    model_stage(1, NPTS / 2);
    run_stage(1, 1 + 2 * NPTS);
    for (int i = 0; i < NPTS; i++) check("s1_const", int'(ram[i]), s1_req[i]);
    check("tw_count", tw_seen.size(), 4);
    if (tw_seen.size() == 4) begin
      check("tw_seq0", tw_seen[0], 0);
      check("tw_seq1", tw_seen[1], 2);
      check("tw_seq2", tw_seen[2], 0);
      check("tw_seq3", tw_seen[3], 2);
    end

    // Abort during the LOAD of butterfly 1.
    for (int i = 0; i < NPTS; i++) img[i] = LOGQ'(i + 1);
    for (int i = 0; i < NTW; i++) rom[i] = LOGQ'(1);
    commit_img();
    model_stage(0, 1);
    @(negedge clk);
    stage = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_we", int'(bus.coef_we), 0);
    check("abort_pe_a", int'(bus.pe_a), 0);
    check("abort_pe_b", int'(bus.pe_b), 0);
    check("abort_raddr_a", int'(bus.coef_raddr_a), 0);
    check("abort_writes", exp_q.size(), 0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    rst_n = 1'b1;
    check_ram();
    model_stage(0, NPTS / 2);
    run_stage(0, 1 + 2 * NPTS);

    // start held high: second run accepted at the end of cycle 18.
    for (int i = 0; i < NPTS; i++) img[i] = LOGQ'($urandom_range(0, Q - 1));
    commit_img();
    model_stage(0, NPTS / 2);
    model_stage(0, NPTS / 2);
    @(negedge clk);
    stage = '0;
    start = 1'b1;
    d1 = 0;
    d2 = 0;
    nd = 0;
    @(negedge clk);
    for (int i = 1; i <= 80; i++) begin
      if (i == 18) check("held_idle_busy", int'(busy), 0);
      if (i == 19) begin
        check("held_restart_busy", int'(busy), 1);
        start = 1'b0;
      end
      if (done) begin
        nd++;
        if (nd == 1) d1 = i;
        if (nd == 2) d2 = i;
      end
      if (nd == 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    check("held_done1", d1, 17);
    check("held_done2", d2, 35);
    @(negedge clk);
    check("held_writes_left", exp_q.size(), 0);
    check_ram();

    // Out-of-range stage: immediate done, RAM untouched.
    run_stage(3, 1);

    for (int n = 0; n < 6; n++) begin
      s = int'($urandom_range(0, LOGN - 1));
      for (int i = 0; i < NPTS; i++) img[i] = LOGQ'($urandom_range(0, Q - 1));
      for (int i = 0; i < NTW; i++) rom[i] = LOGQ'($urandom_range(0, Q - 1));
      commit_img();
      model_stage(s, NPTS / 2);
      run_stage(s, 1 + 2 * NPTS);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
